// File: rtl/vector_pkg.sv
// Shared definitions for the vector-display image ROM pair and its sequencer.
package vector_pkg;

  localparam int DEPTH      = 2387;
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2,
    ST_FLUSH  = 2'd3
  } vfs_state_t;

  // Next ROM address, wrapping from the last word back to word 0.
  function automatic logic [ADDR_WIDTH-1:0] wrap_inc(input logic [ADDR_WIDTH-1:0] a);
    return (a == ADDR_WIDTH'(DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

endpackage

// File: rtl/rate_divider.sv
// Sample-rate divider: counts 0..i_div while enabled and ticks on each count
// of 0, so the first enabled cycle after a clear is a tick and ticks are
// i_div+1 cycles apart.
module rate_divider #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clear,
  input  logic                 i_en,
  input  logic [DIV_WIDTH-1:0] i_div,
  output logic                 o_tick
);

  logic [DIV_WIDTH-1:0] count;

  // Wrapping phase counter; clear has priority over counting.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      count <= '0;
    end else if (i_en) begin
      count <= (count == i_div) ? '0 : count + 1'b1;
    end
  end

  assign o_tick = i_en && (count == '0);

endmodule

// File: rtl/vector_frame_sequencer.sv
// Paced, start/stop-controlled address generator for the X/Y image ROM pair.
// Plays a window [base, base+len) modulo DEPTH for a number of passes, each
// pass preceded by a blanked settle interval so the beam can retrace.
//
// Interface protocol: i_start and i_stop are single-cycle request pulses with
// no back-pressure; i_start is honoured only while o_busy is low, i_stop only
// while o_busy is high, and start wins if both arrive together in IDLE.
// Towards the ROM, o_rom_en is a one-cycle read strobe qualifying o_rom_addr
// in the same cycle; o_sample_valid follows it exactly one cycle later when
// the registered ROM data is ready for the DAC. Neither side can stall.
module vector_frame_sequencer
  import vector_pkg::*;
#(
  parameter int DIV_WIDTH     = 8,
  parameter int REP_WIDTH     = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic [ADDR_WIDTH-1:0] i_base,
  input  logic [ADDR_WIDTH:0]   i_len,
  input  logic [REP_WIDTH-1:0]  i_repeat,
  input  logic [DIV_WIDTH-1:0]  i_div,
  output logic [ADDR_WIDTH-1:0] o_rom_addr,
  output logic                  o_rom_en,
  output logic                  o_sample_valid,
  output logic                  o_blank,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [REP_WIDTH-1:0]  o_pass_cnt,
  output logic [1:0]            o_state
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

  vfs_state_t            state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [REP_WIDTH-1:0]  rep_q;
  logic [DIV_WIDTH-1:0]  div_q;
  logic [SET_W-1:0]      settle_cnt;
  logic [ADDR_WIDTH:0]   sample_cnt;
  logic [ADDR_WIDTH:0]   sample_next;
  logic [REP_WIDTH:0]    pass_next;
  logic                  stop_pend;
  logic                  tick;
  logic                  in_run;

  assign in_run      = (state == ST_RUN);
  assign sample_next = sample_cnt + 1'b1;
  assign pass_next   = {1'b0, o_pass_cnt} + 1'b1;

  // The divider only runs in RUN and sits cleared elsewhere, so every pass
  // starts with a tick on its first RUN cycle.
  rate_divider #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_rate_divider (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (!in_run),
    .i_en    (in_run),
    .i_div   (div_q),
    .o_tick  (tick)
  );

  // Strobe and blanking are decoded from registered state only.
  assign o_rom_en = in_run && tick;
  assign o_blank  = !(state == ST_RUN || state == ST_FLUSH);
  assign o_busy   = (state != ST_IDLE);
  assign o_state  = state;

  // Playback sequencer: settle, run the window, flush the last sample, repeat.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state          <= ST_IDLE;
      base_q         <= '0;
      len_q          <= '0;
      rep_q          <= '0;
      div_q          <= '0;
      settle_cnt     <= '0;
      sample_cnt     <= '0;
      stop_pend      <= 1'b0;
      o_rom_addr     <= '0;
      o_sample_valid <= 1'b0;
      o_done         <= 1'b0;
      o_pass_cnt     <= '0;
    end else begin
      o_done         <= 1'b0;
      o_sample_valid <= o_rom_en;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            base_q     <= i_base;
            len_q      <= i_len;
            rep_q      <= i_repeat;
            div_q      <= i_div;
            o_rom_addr <= i_base;
            o_pass_cnt <= '0;
            settle_cnt <= '0;
            sample_cnt <= '0;
            stop_pend  <= 1'b0;
            if (i_len == '0) begin
              // Empty window: report completion without touching the ROM.
              o_done <= 1'b1;
            end else begin
              state <= ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          if (i_stop) begin
            state  <= ST_IDLE;
            o_done <= 1'b1;
          end else if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
            state      <= ST_RUN;
            sample_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (tick) begin
            o_rom_addr <= wrap_inc(o_rom_addr);
            sample_cnt <= sample_next;
          end
          // A stop lets a same-cycle tick complete, then drains via FLUSH.
          if (i_stop) begin
            stop_pend <= 1'b1;
            state     <= ST_FLUSH;
          end else if (tick && (sample_next == len_q)) begin
            state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (stop_pend) begin
            state  <= ST_IDLE;
            o_done <= 1'b1;
          end else begin
            if (!(&o_pass_cnt)) begin
              o_pass_cnt <= o_pass_cnt + 1'b1;
            end
            if (!i_stop && ((rep_q == '0) || (pass_next < {1'b0, rep_q}))) begin
              state      <= ST_SETTLE;
              o_rom_addr <= base_q;
              settle_cnt <= '0;
            end else begin
              state  <= ST_IDLE;
              o_done <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_frame_sequencer.sv
// Directed bench for vector_frame_sequencer: a table of playback jobs with
// hand-computed outcomes, plus hand-written stop, empty-window and reset
// sequences. A per-cycle monitor models the expected address stream.
module tb_vector_frame_sequencer;
  import vector_pkg::*;

  localparam int DIV_WIDTH = 8;
  localparam int REP_WIDTH = 8;

  logic                  i_clk;
  logic                  i_rst_n;
  logic                  i_start;
  logic                  i_stop;
  logic [ADDR_WIDTH-1:0] i_base;
  logic [ADDR_WIDTH:0]   i_len;
  logic [REP_WIDTH-1:0]  i_repeat;
  logic [DIV_WIDTH-1:0]  i_div;
  logic [ADDR_WIDTH-1:0] o_rom_addr;
  logic                  o_rom_en;
  logic                  o_sample_valid;
  logic                  o_blank;
  logic                  o_busy;
  logic                  o_done;
  logic [REP_WIDTH-1:0]  o_pass_cnt;
  logic [1:0]            o_state;

  vector_frame_sequencer #(
    .DIV_WIDTH     (DIV_WIDTH),
    .REP_WIDTH     (REP_WIDTH),
    .SETTLE_CYCLES (4)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_start        (i_start),
    .i_stop         (i_stop),
    .i_base         (i_base),
    .i_len          (i_len),
    .i_repeat       (i_repeat),
    .i_div          (i_div),
    .o_rom_addr     (o_rom_addr),
    .o_rom_en       (o_rom_en),
    .o_sample_valid (o_sample_valid),
    .o_blank        (o_blank),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_pass_cnt     (o_pass_cnt),
    .o_state        (o_state)
  );

  // ---------------- clock ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  int cyc, en_cnt, last_addr, addr_err, gap_err, lag_err, done_cnt, done_cyc, last_en_cyc;
  int exp_base, exp_len, exp_div;
  logic prev_en;
  logic seen_blank;
  logic [ADDR_WIDTH-1:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One cycle of monitoring, sampled on the falling edge.
  task automatic tick_mon();
    int ea;
    @(negedge i_clk);
    cyc++;
    if (o_sample_valid !== (prev_en && i_rst_n)) lag_err++;
    if ((o_rom_en || o_sample_valid) && o_blank) lag_err++;
    if (o_rom_en) begin
      if (exp_len == 0) begin
        addr_err++;
      end else begin
        ea = (exp_base + (en_cnt % exp_len)) % DEPTH;
        exp_q.push_back(ADDR_WIDTH'(ea));
        if (o_rom_addr != exp_q.pop_front()) addr_err++;
      end
      if (en_cnt > 0 && !seen_blank && (cyc - last_en_cyc) != exp_div + 1) gap_err++;
      last_en_cyc = cyc;
      seen_blank  = 1'b0;
      last_addr   = o_rom_addr;
      en_cnt++;
    end
    if (o_blank) seen_blank = 1'b1;
    if (o_done) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = cyc;
    end
    prev_en = o_rom_en;
  endtask

  // Start a job at the current falling edge and monitor until done (+4 idle
  // cycles) or until one cycle after a planted reset. stop_at=0 raises stop
  // together with start.
  task automatic play(input int b, input int l, input int r, input int d,
                      input int stop_at, input int rst_at);
    logic finished;
    cyc = 0; en_cnt = 0; last_addr = -1; addr_err = 0; gap_err = 0; lag_err = 0;
    done_cnt = 0; done_cyc = -1; last_en_cyc = 0; seen_blank = 1'b1;
    exp_base = b; exp_len = l; exp_div = d;
    exp_q.delete();
    i_base = ADDR_WIDTH'(b); i_len = (ADDR_WIDTH+1)'(l);
    i_repeat = REP_WIDTH'(r); i_div = DIV_WIDTH'(d);
    i_start = 1'b1;
    i_stop  = (stop_at == 0);
    finished = 1'b0;
    for (int k = 0; k < 2000 && !finished; k++) begin
      tick_mon();
      i_start  = 1'b0;
      // Inputs are scrambled after the start; the job must not notice.
      i_base   = ADDR_WIDTH'($urandom_range(0, DEPTH - 1));
      i_len    = (ADDR_WIDTH+1)'($urandom_range(0, 50));
      i_repeat = REP_WIDTH'($urandom_range(0, 255));
      i_div    = DIV_WIDTH'($urandom_range(0, 255));
      i_stop   = (cyc == stop_at);
      i_rst_n  = !(cyc == rst_at);
      if (rst_at >= 0 && cyc == rst_at + 1) finished = 1'b1;
      if (done_cyc >= 0 && cyc >= done_cyc + 4) finished = 1'b1;
    end
    i_stop = 1'b0;
    if (!finished) chk("timeout", 1, 0);
  endtask

  typedef struct {
    int base;
    int len;
    int rep;
    int div;
    int exp_ens;
    int exp_last;
    int exp_pass;
    int exp_done_cyc;
  } vec_t;

  vec_t vecs[5];

  task automatic chk_run(input string tag, input int ens, input int last, input int pass, input int dcyc);
    chk({tag, " en_count"}, en_cnt, ens);
    chk({tag, " last_addr"}, last_addr, last);
    chk({tag, " pass_cnt"}, int'(o_pass_cnt), pass);
    chk({tag, " done_cycle"}, done_cyc, dcyc);
    chk({tag, " done_pulses"}, done_cnt, 1);
    chk({tag, " addr_errors"}, addr_err, 0);
    chk({tag, " gap_errors"}, gap_err, 0);
    chk({tag, " valid_blank_errors"}, lag_err, 0);
  endtask

  initial begin
    // Done cycle counts falling edges after the start edge:
    // one pass = 4 settle + RUN ((len-1)*(div+1)+1) + 1 flush, done one later.
    vecs[0] = '{base: 0,    len: 5, rep: 1, div: 0, exp_ens: 5, exp_last: 4,    exp_pass: 1, exp_done_cyc: 11};
    vecs[1] = '{base: 2385, len: 4, rep: 1, div: 0, exp_ens: 4, exp_last: 1,    exp_pass: 1, exp_done_cyc: 10};
    vecs[2] = '{base: 10,   len: 3, rep: 1, div: 2, exp_ens: 3, exp_last: 12,   exp_pass: 1, exp_done_cyc: 13};
    vecs[3] = '{base: 100,  len: 2, rep: 3, div: 0, exp_ens: 6, exp_last: 101,  exp_pass: 3, exp_done_cyc: 22};
    vecs[4] = '{base: 7,    len: 1, rep: 2, div: 5, exp_ens: 2, exp_last: 7,    exp_pass: 2, exp_done_cyc: 13};

    // ---------------- reset ----------------
    i_rst_n = 1'b0; i_start = 1'b0; i_stop = 1'b0;
    i_base = '0; i_len = '0; i_repeat = '0; i_div = '0;
    prev_en = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("reset rom_addr", int'(o_rom_addr), 0);
    chk("reset rom_en", int'(o_rom_en), 0);
    chk("reset sample_valid", int'(o_sample_valid), 0);
    chk("reset blank", int'(o_blank), 1);
    chk("reset busy", int'(o_busy), 0);
    chk("reset done", int'(o_done), 0);
    chk("reset pass_cnt", int'(o_pass_cnt), 0);
    chk("reset state", int'(o_state), 0);
    i_rst_n = 1'b1;
    tick_mon();
    tick_mon();
    // A stop while idle must not wake the block.
    i_stop = 1'b1;
    tick_mon();
    i_stop = 1'b0;
    chk("idle stop ignored busy", int'(o_busy), 0);
    chk("idle stop ignored done", int'(o_done), 0);

    // ---------------- table-driven jobs ----------------
    for (int i = 0; i < 5; i++) begin
      play(vecs[i].base, vecs[i].len, vecs[i].rep, vecs[i].div, -1, -1);
      chk_run($sformatf("vec%0d", i), vecs[i].exp_ens, vecs[i].exp_last,
              vecs[i].exp_pass, vecs[i].exp_done_cyc);
    end

    // ---------------- empty window ----------------
    play(500, 0, 1, 0, -1, -1);
    chk("len0 done_cycle", done_cyc, 1);
    chk("len0 en_count", en_cnt, 0);
    chk("len0 done_pulses", done_cnt, 1);
    chk("len0 busy", int'(o_busy), 0);

    // ---------------- endless play stopped in pass 2 ----------------
    // Pass length 16 edges (div=1, len=6); pass-2 ticks at cycles 21,23,25.
    // Stop during the tick at cycle 23 keeps that sample (addr 51).
    play(50, 6, 0, 1, 23, -1);
    chk_run("stop_run", 8, 51, 1, 25);

    // ---------------- stop during settle ----------------
    play(3, 4, 1, 0, 2, -1);
    chk("stop_settle done_cycle", done_cyc, 3);
    chk("stop_settle en_count", en_cnt, 0);
    chk("stop_settle pass_cnt", int'(o_pass_cnt), 0);
    chk("stop_settle done_pulses", done_cnt, 1);

    // ---------------- start and stop together: start wins ----------------
    play(20, 2, 1, 0, 0, -1);
    chk_run("start_stop", 2, 21, 1, 8);

    // ---------------- reset in the middle of RUN ----------------
    play(30, 8, 1, 0, -1, 6);
    chk("midrst en_before", en_cnt, 2);
    chk("midrst rom_addr", int'(o_rom_addr), 0);
    chk("midrst rom_en", int'(o_rom_en), 0);
    chk("midrst sample_valid", int'(o_sample_valid), 0);
    chk("midrst blank", int'(o_blank), 1);
    chk("midrst busy", int'(o_busy), 0);
    chk("midrst pass_cnt", int'(o_pass_cnt), 0);
    chk("midrst done_pulses", done_cnt, 0);
    chk("midrst lag_errors", lag_err, 0);
    play(30, 2, 1, 0, -1, -1);
    chk_run("replay", 2, 31, 1, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
